// File: rtl/intf_rr_arbiter.sv
// Packet-level round-robin arbiter: N_REQ valid/ready requesters share one W-bit channel.
// A grant is held from a packet's first beat through its last beat, so packets never interleave.
module intf_rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int unsigned IdW = $clog2(N_REQ);

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } state_e;

    state_e         state_q, state_d;
    logic [IdW-1:0] grant_id_q, grant_id_d;
    logic [IdW-1:0] ptr_q, ptr_d;

    logic           pick_found;
    logic [IdW-1:0] pick_idx;
    logic           last_fire;

    // Round-robin pick: requesters above ptr take priority, then wrap to 0..ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!pick_found && req_valid[i] && (IdW'(i) > ptr_q)) begin
                pick_found = 1'b1;
                pick_idx   = IdW'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!pick_found && req_valid[i] && (IdW'(i) <= ptr_q)) begin
                pick_found = 1'b1;
                pick_idx   = IdW'(i);
            end
        end
    end

    assign last_fire = (state_q == StLock) && out_valid && out_ready && out_last;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grant_id_q <= '0;
            ptr_q      <= IdW'(N_REQ - 1);
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    state_d    = StLock;
                end
            end
            StLock: begin
                if (last_fire) begin
                    ptr_d   = grant_id_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic: only the granted lane is ever selected, so X on other lanes stays out.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        req_ready = '0;
        if (state_q == StLock) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant_id_q == IdW'(i)) begin
                    out_valid    = req_valid[i];
                    out_data     = req_data[i*W +: W];
                    out_last     = req_last[i];
                    req_ready[i] = out_ready;
                end
            end
        end
    end

    assign busy     = (state_q == StLock);
    assign grant_id = grant_id_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_valid_needs_busy: assert property (@(posedge clk) disable iff (!rst_n)
        out_valid |-> busy);
    a_grant_held: assert property (@(posedge clk) disable iff (!rst_n)
        (busy && !last_fire) |=> (busy && $stable(grant_id)));
    a_idle_after_last: assert property (@(posedge clk) disable iff (!rst_n)
        last_fire |=> !busy);

endmodule
